pipe_ctrl: RTL and testbench

PIPE_CTRL -- requirements
Module: pipe_ctrl

---
 rtl/pipe_ctrl.sv | 155 +++++++++++++++
 tb/tb_pipe_ctrl.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/pipe_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_ctrl -- five-stage pipeline hazard / exception controller.
//
// Combines fetch, load-use, multi-cycle mult/div and data-memory stall
// requests into a per-stage hold vector. It also sequences exception flushes
// with a PC redirect, and watches every mult/div operation with a cycle
// watchdog.
//
// Parameters
//   MD_MAX_CYCLES  watchdog limit in cycles for one mult/div operation
//
// Ports
//   clk             in   sole clock, rising edge
//   rst             in   asynchronous active-high reset
//   if_stall_req    in   instruction fetch not ready
//   id_load_hazard  in   ID source written by the load currently in EX
//   ex_md_start     in   EX issues a multi-cycle mult/div (1-cycle pulse)
//   ex_md_done      in   mult/div result valid this cycle
//   mem_stall_req   in   data memory not ready
//   exc_flush       in   exception committed in MEM
//   exc_pc[31:0]    in   handler address accompanying exc_flush
//   stall[4:0]      out  per-stage hold, bit0=IF .. bit4=WB
//   flush[4:0]      out  per-stage clear, same bit order
//   redirect_valid  out  PC redirect strobe
//   redirect_pc     out  redirect target
//   md_busy         out  mult/div wait in progress
//   md_timeout      out  watchdog expiry pulse
//   md_abort        out  mult/div cancelled by exception pulse
//   stall_cycles    out  saturating count of cycles with stall != 0
// -----------------------------------------------------------------------------
module pipe_ctrl #(
    parameter int MD_MAX_CYCLES = 40
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_stall_req,
    input  logic        id_load_hazard,
    input  logic        ex_md_start,
    input  logic        ex_md_done,
    input  logic        mem_stall_req,
    input  logic        exc_flush,
    input  logic [31:0] exc_pc,
    output logic [4:0]  stall,
    output logic [4:0]  flush,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    output logic        md_busy,
    output logic        md_timeout,
    output logic        md_abort,
    output logic [31:0] stall_cycles
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MD_WAIT = 2'd1,
        FLUSH   = 2'd2
    } state_t;

    localparam int           CW       = $clog2(MD_MAX_CYCLES + 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_LAST = CW'(MD_MAX_CYCLES - 1);

    state_t        state_r;
    logic [CW-1:0] md_cnt_r;
    logic [31:0]   redirect_pc_r;
    logic [31:0]   stall_cycles_r;

    logic [4:0]    stall_s;
    logic          md_hold_s;
    logic          md_limit_s;

    // Stall request decode. Every request also holds all stages upstream of
    // it; the stage just above the highest held stage picks up a bubble from
    // the downstream pipeline register, so no flush is produced for it.
    always_comb begin
        md_hold_s  = ((state_r == IDLE) && ex_md_start) ||
                     ((state_r == MD_WAIT) && !ex_md_done);
        md_limit_s = (state_r == MD_WAIT) && (md_cnt_r == CNT_LAST) && !ex_md_done;
        if (rst || (state_r == FLUSH)) begin
            stall_s = 5'b00000;
        end else begin
            stall_s = ({5{if_stall_req}}   & 5'b00001) |
                      ({5{id_load_hazard}} & 5'b00011) |
                      ({5{md_hold_s}}      & 5'b00111) |
                      ({5{mem_stall_req}}  & 5'b01111);
        end
    end

    // Control FSM, mult/div watchdog counter, redirect latch and stall counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r        <= IDLE;
            md_cnt_r       <= '0;
            redirect_pc_r  <= 32'h0000_0000;
            stall_cycles_r <= 32'h0000_0000;
        end else begin
            if ((stall_s != 5'b00000) && (stall_cycles_r != 32'hFFFF_FFFF)) begin
                stall_cycles_r <= stall_cycles_r + 32'd1;
            end else begin
                stall_cycles_r <= stall_cycles_r;
            end

            case (state_r)
                IDLE: begin
                    if (exc_flush) begin
                        state_r       <= FLUSH;
                        redirect_pc_r <= exc_pc;
                    end else if (ex_md_start) begin
                        state_r  <= MD_WAIT;
                        md_cnt_r <= '0;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                MD_WAIT: begin
                    md_cnt_r <= md_cnt_r + CNT_ONE;
                    if (exc_flush) begin
                        state_r       <= FLUSH;
                        redirect_pc_r <= exc_pc;
                    end else if (ex_md_done || md_limit_s) begin
                        state_r <= IDLE;
                    end else begin
                        state_r <= MD_WAIT;
                    end
                end
                FLUSH: begin
                    // Back-to-back exceptions keep the flush going and take
                    // the newest handler address.
                    if (exc_flush) begin
                        state_r       <= FLUSH;
                        redirect_pc_r <= exc_pc;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                default: begin
                    state_r  <= IDLE;
                    md_cnt_r <= '0;
                end
            endcase
        end
    end

    // A pending exception takes precedence over the watchdog, so an expiring
    // operation that is also being flushed reports an abort, not a timeout.
    assign stall          = stall_s;
    assign flush          = (state_r == FLUSH) ? 5'b01111 : 5'b00000;
    assign redirect_valid = (state_r == FLUSH);
    assign redirect_pc    = redirect_pc_r;
    assign md_busy        = (state_r == MD_WAIT);
    assign md_timeout     = md_limit_s && !exc_flush;
    assign md_abort       = (state_r == MD_WAIT) && exc_flush;
    assign stall_cycles   = stall_cycles_r;

endmodule

// File: tb/tb_pipe_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipe_ctrl -- directed, table-driven bench for pipe_ctrl.
// Each table row is one clock cycle: inputs driven after the rising edge, and
// outputs compared on the falling edge of that same cycle.
// -----------------------------------------------------------------------------
module tb_pipe_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_stall_req, id_load_hazard, ex_md_start, ex_md_done;
    logic        mem_stall_req, exc_flush;
    logic [31:0] exc_pc;
    logic [4:0]  stall, flush;
    logic        redirect_valid, md_busy, md_timeout, md_abort;
    logic [31:0] redirect_pc, stall_cycles;

    int n_tests = 0;
    int n_fail  = 0;

    pipe_ctrl #(.MD_MAX_CYCLES(40)) dut (
        .clk(clk), .rst(rst),
        .if_stall_req(if_stall_req), .id_load_hazard(id_load_hazard),
        .ex_md_start(ex_md_start), .ex_md_done(ex_md_done),
        .mem_stall_req(mem_stall_req), .exc_flush(exc_flush), .exc_pc(exc_pc),
        .stall(stall), .flush(flush), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .md_busy(md_busy), .md_timeout(md_timeout),
        .md_abort(md_abort), .stall_cycles(stall_cycles)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        ifs, idh, mds, mdd, mems, exc;
        logic [31:0] pc;
        logic [4:0]  e_stall, e_flush;
        logic        e_rv, e_busy, e_abort, e_to;
        logic [31:0] e_rpc, e_sc;
    } vec_t;

    vec_t vecs[23];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic ifs, idh, mds, mdd, mems, exc, input logic [31:0] pc);
        if_stall_req = ifs; id_load_hazard = idh; ex_md_start = mds;
        ex_md_done = mdd; mem_stall_req = mems; exc_flush = exc; exc_pc = pc;
    endtask

    function automatic vec_t mk(input logic ifs, idh, mds, mdd, mems, exc,
                                input logic [31:0] pc, input logic [4:0] es, ef,
                                input logic rv, bz, ab, to,
                                input logic [31:0] rpc, sc);
        vec_t v;
        v.ifs = ifs; v.idh = idh; v.mds = mds; v.mdd = mdd; v.mems = mems;
        v.exc = exc; v.pc = pc; v.e_stall = es; v.e_flush = ef; v.e_rv = rv;
        v.e_busy = bz; v.e_abort = ab; v.e_to = to; v.e_rpc = rpc; v.e_sc = sc;
        return v;
    endfunction

    initial begin
        //            ifs  idh  mds  mdd  mem  exc  exc_pc         stall     flush     rv   busy abrt to   rpc            sc
        vecs[0]  = mk(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,32'h0,         5'b00000, 5'b00000, 1'b0,1'b0,1'b0,1'b0,32'h0,         32'd0);
        vecs[1]  = mk(1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,32'h0,         5'b00011, 5'b00000, 1'b0,1'b0,1'b0,1'b0,32'h0,         32'd0);
        vecs[2]  = mk(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,32'h0,         5'b00000, 5'b00000, 1'b0,1'b0,1'b0,1'b0,32'h0,         32'd1);
        vecs[3]  = mk(1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,32'h0,         5'b00001, 5'b00000, 1'b0,1'b0,1'b0,1'b0,32'h0,         32'd1);
        vecs[4]  = mk(1'b1,1'b0,1'b0,1'b0,1'b1,1'b0,32'h0,         5'b01111, 5'b00000, 1'b0,1'b0,1'b0,1'b0,32'h0,         32'd2);
        vecs[5]  = mk(1'b1,1'b0,1'b0,1'b0,1'b1,1'b1,32'h8000_0180, 5'b01111, 5'b00000, 1'b0,1'b0,1'b0,1'b0,32'h0,         32'd3);
        vecs[6]  = mk(1'b1,1'b0,1'b0,1'b0,1'b1,1'b0,32'h0,         5'b00000, 5'b01111, 1'b1,1'b0,1'b0,1'b0,32'h8000_0180, 32'd4);
        vecs[7]  = mk(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,32'h0,         5'b00000, 5'b00000, 1'b0,1'b0,1'b0,1'b0,32'h8000_0180, 32'd4);
        vecs[8]  = mk(1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,32'h0,         5'b00111, 5'b00000, 1'b0,1'b0,1'b0,1'b0,32'h8000_0180, 32'd4);
        vecs[9]  = mk(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,32'h0,         5'b00111, 5'b00000, 1'b0,1'b1,1'b0,1'b0,32'h8000_0180, 32'd5);
        vecs[10] = mk(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,32'h0,         5'b00111, 5'b00000, 1'b0,1'b1,1'b0,1'b0,32'h8000_0180, 32'd6);
        vecs[11] = mk(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,32'h0,         5'b00111, 5'b00000, 1'b0,1'b1,1'b0,1'b0,32'h8000_0180, 32'd7);
        vecs[12] = mk(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,32'h0,         5'b00111, 5'b00000, 1'b0,1'b1,1'b0,1'b0,32'h8000_0180, 32'd8);
        vecs[13] = mk(1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,32'h0,         5'b00000, 5'b00000, 1'b0,1'b1,1'b0,1'b0,32'h8000_0180, 32'd9);
        vecs[14] = mk(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,32'h0,         5'b00000, 5'b00000, 1'b0,1'b0,1'b0,1'b0,32'h8000_0180, 32'd9);
        vecs[15] = mk(1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,32'h0,         5'b00111, 5'b00000, 1'b0,1'b0,1'b0,1'b0,32'h8000_0180, 32'd9);
        vecs[16] = mk(1'b0,1'b0,1'b1,1'b0,1'b0,1'b1,32'hBFC0_0380, 5'b00111, 5'b00000, 1'b0,1'b1,1'b1,1'b0,32'h8000_0180, 32'd10);
        vecs[17] = mk(1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,32'h0000_1234, 5'b00000, 5'b01111, 1'b1,1'b0,1'b0,1'b0,32'hBFC0_0380, 32'd11);
        vecs[18] = mk(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,32'h0,         5'b00000, 5'b01111, 1'b1,1'b0,1'b0,1'b0,32'h0000_1234, 32'd11);
        vecs[19] = mk(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,32'h0,         5'b00000, 5'b00000, 1'b0,1'b0,1'b0,1'b0,32'h0000_1234, 32'd11);
        vecs[20] = mk(1'b0,1'b0,1'b1,1'b0,1'b0,1'b1,32'hDEAD_BEE0, 5'b00111, 5'b00000, 1'b0,1'b0,1'b0,1'b0,32'h0000_1234, 32'd11);
        vecs[21] = mk(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,32'h0,         5'b00000, 5'b01111, 1'b1,1'b0,1'b0,1'b0,32'hDEAD_BEE0, 32'd12);
        vecs[22] = mk(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,32'h0,         5'b00000, 5'b00000, 1'b0,1'b0,1'b0,1'b0,32'hDEAD_BEE0, 32'd12);

        // Reset held with active requests: every output must stay at zero.
        rst = 1'b1;
        drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 32'hFFFF_FFFF);
        @(negedge clk);
        chk("rst_stall", {27'd0, stall}, 32'd0);
        chk("rst_flush", {27'd0, flush}, 32'd0);
        chk("rst_misc", {28'd0, redirect_valid, md_busy, md_timeout, md_abort}, 32'd0);
        chk("rst_rpc", redirect_pc, 32'd0);
        chk("rst_sc", stall_cycles, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Table of single-cycle vectors.
        for (int i = 0; i < 23; i++) begin
            drive(vecs[i].ifs, vecs[i].idh, vecs[i].mds, vecs[i].mdd,
                  vecs[i].mems, vecs[i].exc, vecs[i].pc);
            @(negedge clk);
            chk($sformatf("v%0d_stall", i), {27'd0, stall}, {27'd0, vecs[i].e_stall});
            chk($sformatf("v%0d_flush", i), {27'd0, flush}, {27'd0, vecs[i].e_flush});
            chk($sformatf("v%0d_rv", i), {31'd0, redirect_valid}, {31'd0, vecs[i].e_rv});
            chk($sformatf("v%0d_busy", i), {31'd0, md_busy}, {31'd0, vecs[i].e_busy});
            chk($sformatf("v%0d_abort", i), {31'd0, md_abort}, {31'd0, vecs[i].e_abort});
            chk($sformatf("v%0d_to", i), {31'd0, md_timeout}, {31'd0, vecs[i].e_to});
            chk($sformatf("v%0d_rpc", i), redirect_pc, vecs[i].e_rpc);
            chk($sformatf("v%0d_sc", i), stall_cycles, vecs[i].e_sc);
            @(posedge clk); #1;
        end

        // Watchdog: start, never done; timeout on the 40th MD_WAIT cycle.
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        chk("to_start_stall", {27'd0, stall}, 32'd7);
        @(posedge clk); #1;
        ex_md_start = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            chk($sformatf("to_c%0d_to", c), {31'd0, md_timeout}, (c == 40) ? 32'd1 : 32'd0);
            chk($sformatf("to_c%0d_busy", c), {31'd0, md_busy}, 32'd1);
            chk($sformatf("to_c%0d_stall", c), {27'd0, stall}, 32'd7);
            @(posedge clk); #1;
        end
        @(negedge clk);
        chk("to_after_busy", {31'd0, md_busy}, 32'd0);
        chk("to_after_to", {31'd0, md_timeout}, 32'd0);
        chk("to_after_stall", {27'd0, stall}, 32'd0);
        chk("to_after_sc", stall_cycles, 32'd53);

        // Asynchronous reset in the middle of MD_WAIT with an exception pending.
        @(posedge clk); #1;
        ex_md_start = 1'b1;
        @(posedge clk); #1;
        ex_md_start = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        chk("rw_busy_before", {31'd0, md_busy}, 32'd1);
        #2;
        rst = 1'b1;
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h1111_2222);
        #1;
        chk("rw_stall", {27'd0, stall}, 32'd0);
        chk("rw_busy", {31'd0, md_busy}, 32'd0);
        chk("rw_abort", {31'd0, md_abort}, 32'd0);
        chk("rw_to", {31'd0, md_timeout}, 32'd0);
        chk("rw_flush_rv", {26'd0, flush, redirect_valid}, 32'd0);
        chk("rw_rpc", redirect_pc, 32'd0);
        chk("rw_sc", stall_cycles, 32'd0);
        @(posedge clk); #1;
        chk("rw_hold_rpc", redirect_pc, 32'd0);
        rst = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        chk("rw_after_busy", {31'd0, md_busy}, 32'd0);
        chk("rw_after_flush", {27'd0, flush}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
